disp_feeder: RTL and testbench
==============================

# disp_feeder

Upstream front end for the seven-segment display driver in the MIPS CPU debug path. It debounces two board push-buttons and steps through a fixed set of CPU debug sources: PC, instruction, ALU result and general registers. It presents the selected 32-bit word, the half-word select and a divided scan clock to the display driver. It also drives the register-file debug read address.

## Interface
Parameters:
- DIV_BITS, 16: width of the free-running scan divider; scan_clk = divider bit DIV_BITS-1.
- DB_CYCLES, 20000: consecutive differing samples needed to accept a button level change (≥2).
- AUTO_HL, 0: period in cycles of automatic hi_lo toggling; 0 disables it.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- btn_next  in  1  raw asynchronous push-button; advances the source.
- btn_half  in  1  raw asynchronous push-button; toggles the displayed half.
- pc  in  32  current PC.
- instr  in  32  current instruction.
- alu_out  in  32  ALU result.
- reg_rdata  in  32  register-file debug read data, combinational from reg_raddr.
- reg_raddr  out  5  register-file debug read address.
- mode  out  2  current source: 0 PC, 1 INSTR, 2 ALU, 3 REG.
- data  out  32  selected word, registered.
- hi_lo  out  1  1 shows data[31:16], 0 shows data[15:0].
- scan_clk  out  1  digit-scan clock for the display driver, registered.

## Operation
- Synchronizer: each button passes through 2 flip-flops. Call the output s.
- Debouncer, one per button: holds a stable level st and a counter cnt.
  - If s == st, cnt <= 0.
  - Else, if cnt == DB_CYCLES-1, then st <= s and cnt <= 0.
  - Else, cnt <= cnt+1.
  - A glitch shorter than DB_CYCLES cycles is ignored.
- Press pulse: registered one-cycle pulse, asserted in the same cycle st rises 0→1. A release produces no pulse.
- Mode FSM (states PC, INSTR, ALU, REG), driven by the next-press pulse:
  - PC→INSTR→ALU→REG.
  - In REG, each press increments reg_raddr. When reg_raddr is 31, the press sets reg_raddr to 0 and the state to PC.
  - reg_raddr changes only in REG and keeps its value outside REG (always 0 after a wrap).
- Half-press pulse: hi_lo <= ~hi_lo and clears the auto-toggle counter.
- Auto-toggle, when AUTO_HL ≠ 0: a counter counts 0..AUTO_HL-1. On the wrap cycle, hi_lo toggles.
- Simultaneous half-press and auto wrap in the same cycle: exactly one toggle occurs and the counter clears.
- Simultaneous next-press and half-press: both take effect in the same cycle.
- data: registered every cycle from the mux selected by the current mode (pc / instr / alu_out / reg_rdata). It tracks live source changes with 1-cycle latency.
- Scan divider: free-running DIV_BITS-bit counter. scan_clk is registered from its top bit, giving period 2^DIV_BITS cycles at 50% duty.

## Timing
- Reset values: mode=0, reg_raddr=0, hi_lo=0, data=0, scan_clk=0. All counters, st and synchronizers are 0. Press pulses are 0.
- Reset takes effect at the first clk edge with rst=1, including mid-debounce and mid-REG. After rst falls, an already-held button is re-debounced from zero.
- A raw button rising at cycle t and held produces its pulse in cycle t+2+DB_CYCLES.
- mode and reg_raddr update in cycle t+3+DB_CYCLES.
- data reflects the new source in cycle t+4+DB_CYCLES.
- hi_lo toggles in cycle t+3+DB_CYCLES.
- A source change at cycle k appears on data at cycle k+1.
- scan_clk first rises 2^(DIV_BITS-1)+1 cycles after reset deasserts, then toggles every 2^(DIV_BITS-1) cycles.

## Test plan
Test parameters: DB_CYCLES=4, DIV_BITS=3, AUTO_HL=0 unless stated.
- Reset then idle: scan_clk=0 for 5 cycles, then toggles every 4 cycles. data=pc, pc=0x00400000 → data=0x00400000 one cycle later. hi_lo=0.
- btn_next high for 3 cycles, then low: no pulse, mode stays 0. Held 10 cycles: mode=1 exactly at t+7, data=instr (0x8C080004) at t+8. No second step on release.
- 3 presses reach REG with reg_raddr=0 and data=reg_rdata. 31 further presses give reg_raddr=31. The next press gives reg_raddr=0, mode=0.
- btn_half press: hi_lo 0→1. With AUTO_HL=10: toggles every 10 cycles. A press on a wrap cycle produces a single toggle; the next auto toggle comes 10 cycles later.
- Both buttons pressed on the same cycle in ALU: mode=3 and hi_lo inverted in the same cycle.
- rst asserted with mode=3, reg_raddr=7, btn_next held: next cycle all outputs at reset values. After release, mode advances only after a fresh 2+DB_CYCLES delay.

Source files
------------

// File: rtl/disp_feeder.sv
`timescale 1ns/1ps
// disp_feeder: debounced button front end for the 7-seg debug display.
// Picks a CPU debug word (PC/INSTR/ALU/REG), the shown half and a scan clock.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   btn_next, btn_half  raw push-buttons (async)
//   pc, instr, alu_out  debug sources
//   reg_rdata           regfile debug read data (comb from reg_raddr)
//   reg_raddr           regfile debug read address
//   mode                source: 0 PC, 1 INSTR, 2 ALU, 3 REG
//   data                selected word, registered
//   hi_lo               1 shows data[31:16], 0 shows data[15:0]
//   scan_clk            divided digit-scan clock
module disp_feeder #(
  parameter int DIV_BITS  = 16,
  parameter int DB_CYCLES = 20000,
  parameter int AUTO_HL   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_half,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] alu_out,
  input  logic [31:0] reg_rdata,
  output logic [4:0]  reg_raddr,
  output logic [1:0]  mode,
  output logic [31:0] data,
  output logic        hi_lo,
  output logic        scan_clk
);

  localparam int CW = $clog2(DB_CYCLES);

  typedef enum logic [1:0] {
    S_PC    = 2'd0,
    S_INSTR = 2'd1,
    S_ALU   = 2'd2,
    S_REG   = 2'd3
  } state_t;

  // index 0: next button, index 1: half button
  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    st;
  logic [1:0]    pulse;
  logic [CW-1:0] cnt [2];

  assign raw = {btn_half, btn_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      st     <= '0;
      pulse  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (s2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          st[i]    <= s2[i];
          cnt[i]   <= '0;
          // pulse only on an accepted rising level
          pulse[i] <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t     state;
  state_t     nxt;
  logic [4:0] raddr;
  logic [4:0] nxt_raddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_PC;
      raddr <= '0;
    end else begin
      state <= nxt;
      raddr <= nxt_raddr;
    end
  end

  always_comb begin
    nxt       = state;
    nxt_raddr = raddr;
    if (pulse[0]) begin
      unique case (state)
        S_PC:    nxt = S_INSTR;
        S_INSTR: nxt = S_ALU;
        S_ALU:   nxt = S_REG;
        S_REG: begin
          if (raddr == 5'd31) begin
            nxt       = S_PC;
            nxt_raddr = '0;
          end else begin
            nxt_raddr = raddr + 5'd1;
          end
        end
        default: nxt = S_PC;
      endcase
    end
  end

  always_comb begin
    mode      = state;
    reg_raddr = raddr;
  end

  logic [31:0] sel;

  always_comb begin
    sel = pc;
    unique case (state)
      S_PC:    sel = pc;
      S_INSTR: sel = instr;
      S_ALU:   sel = alu_out;
      S_REG:   sel = reg_rdata;
      default: sel = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) data <= '0;
    else     data <= sel;
  end

  logic wrap;

  generate
    if (AUTO_HL > 0) begin : g_auto
      localparam int AW = (AUTO_HL > 1) ? $clog2(AUTO_HL) : 1;
      logic [AW-1:0] acnt;

      assign wrap = (acnt == AW'(AUTO_HL - 1));

      // a manual toggle restarts the auto period
      always_ff @(posedge clk) begin
        if (rst)                 acnt <= '0;
        else if (pulse[1] || wrap) acnt <= '0;
        else                     acnt <= acnt + 1'b1;
      end
    end else begin : g_noauto
      assign wrap = 1'b0;
    end
  endgenerate

  // press and auto wrap together still give one toggle
  always_ff @(posedge clk) begin
    if (rst)                   hi_lo <= 1'b0;
    else if (pulse[1] || wrap) hi_lo <= ~hi_lo;
  end

  logic [DIV_BITS-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      scan_clk <= 1'b0;
    end else begin
      div      <= div + 1'b1;
      scan_clk <= div[DIV_BITS-1];
    end
  end

endmodule

// File: tb/tb_disp_feeder.sv
`timescale 1ns/1ps
// tb_disp_feeder: scoreboard bench for disp_feeder.
// Stimulus queues timed expectations; a monitor checks them each cycle.
module tb_disp_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        bn;
  logic        bh;
  logic        bn_a;
  logic        bh_a;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] alu;
  logic [31:0] rd;
  logic [31:0] rd_a;
  logic [4:0]  raddr;
  logic [4:0]  raddr_a;
  logic [1:0]  mode;
  logic [1:0]  mode_a;
  logic [31:0] data;
  logic [31:0] data_a;
  logic        hl;
  logic        hl_a;
  logic        scan;
  logic        scan_a;

  always #5 clk = ~clk;

  assign rd   = 32'hA500_0000 | {27'd0, raddr};
  assign rd_a = 32'hA500_0000 | {27'd0, raddr_a};

  disp_feeder #(.DIV_BITS(3), .DB_CYCLES(4), .AUTO_HL(0)) dut (
    .clk(clk), .rst(rst), .btn_next(bn), .btn_half(bh),
    .pc(pc), .instr(instr), .alu_out(alu), .reg_rdata(rd),
    .reg_raddr(raddr), .mode(mode), .data(data),
    .hi_lo(hl), .scan_clk(scan)
  );

  disp_feeder #(.DIV_BITS(3), .DB_CYCLES(4), .AUTO_HL(10)) dut_a (
    .clk(clk), .rst(rst), .btn_next(bn_a), .btn_half(bh_a),
    .pc(pc), .instr(instr), .alu_out(alu), .reg_rdata(rd_a),
    .reg_raddr(raddr_a), .mode(mode_a), .data(data_a),
    .hi_lo(hl_a), .scan_clk(scan_a)
  );

  localparam int G_MODE  = 0;
  localparam int G_RADDR = 1;
  localparam int G_DATA  = 2;
  localparam int G_HL    = 3;
  localparam int G_SCAN  = 4;
  localparam int G_HLA   = 5;
  localparam int G_MODEA = 6;
  localparam int G_RADA  = 7;
  localparam int G_DATAA = 8;
  localparam int G_SCANA = 9;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t keep_q[$];
  int   cyc = 0;
  int   max_at = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get(int s);
    case (s)
      G_MODE:  return {30'd0, mode};
      G_RADDR: return {27'd0, raddr};
      G_DATA:  return data;
      G_HL:    return {31'd0, hl};
      G_SCAN:  return {31'd0, scan};
      G_HLA:   return {31'd0, hl_a};
      G_MODEA: return {30'd0, mode_a};
      G_RADA:  return {27'd0, raddr_a};
      G_DATAA: return data_a;
      G_SCANA: return {31'd0, scan_a};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic ex(input int at, input int sig,
                    input logic [31:0] val, input string name);
    exp_t e;
    e.at   = at;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
    if (at > max_at) max_at = at;
  endtask

  always @(negedge clk) begin
    logic [31:0] act;
    keep_q = {};
    foreach (sb[i]) begin
      if (sb[i].at == cyc) begin
        checks++;
        act = get(sb[i].sig);
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %h want %h",
                   sb[i].name, cyc, act, sb[i].val);
        end
      end else if (sb[i].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc %0d never checked",
                 sb[i].name, sb[i].at);
      end else begin
        keep_q.push_back(sb[i]);
      end
    end
    sb = keep_q;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int x);
    while (cyc < x) @(negedge clk);
  endtask

  task automatic press(input logic n, input logic h);
    bn = n;
    bh = h;
    tick(6);
    bn = 1'b0;
    bh = 1'b0;
    tick(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c;
  int t;
  int r;

  initial begin
    rst   = 1'b1;
    bn    = 1'b0;
    bh    = 1'b0;
    bn_a  = 1'b0;
    bh_a  = 1'b0;
    pc    = 32'h0040_0000;
    instr = 32'h8C08_0004;
    alu   = 32'h1234_5678;
    tick(2);
    ex(cyc + 1, G_DATA, 32'h0, "rst_data");
    ex(cyc + 1, G_SCAN, 32'h0, "rst_scan");
    tick(1);
    c = cyc;
    rst = 1'b0;
    ex(c + 1, G_MODE,  0, "rst_mode");
    ex(c + 1, G_RADDR, 0, "rst_raddr");
    ex(c + 1, G_HL,    0, "rst_hilo");
    ex(c + 1, G_DATA,  32'h0040_0000, "data_pc");
    ex(c + 2, G_DATA,  32'h0040_0000, "data_pc_hold");
    ex(c + 3, G_DATA,  32'h0040_0004, "data_pc_live");
    ex(c + 4, G_SCAN,  0, "scan_lo4");
    ex(c + 5, G_SCAN,  1, "scan_rise");
    ex(c + 8, G_SCAN,  1, "scan_hi8");
    ex(c + 9, G_SCAN,  0, "scan_fall");
    ex(c + 13, G_SCAN, 1, "scan_rise2");
    wait_cyc(c + 2);
    pc = 32'h0040_0004;

    wait_cyc(c + 4);
    t = cyc;
    bn = 1'b1;
    ex(t + 7,  G_MODE, 0, "glitch_mode");
    ex(t + 12, G_MODE, 0, "glitch_mode_late");
    tick(3);
    bn = 1'b0;
    tick(12);

    t = cyc;
    bn = 1'b1;
    ex(t + 6, G_MODE, 0, "press_early");
    ex(t + 7, G_MODE, 1, "press_mode1");
    ex(t + 7, G_DATA, 32'h0040_0004, "press_data_old");
    ex(t + 8, G_DATA, 32'h8C08_0004, "press_data_instr");
    tick(10);
    bn = 1'b0;
    ex(cyc + 12, G_MODE, 1, "release_nostep");
    tick(14);

    t = cyc;
    ex(t + 7, G_MODE, 2, "mode_alu");
    ex(t + 8, G_DATA, 32'h1234_5678, "data_alu");
    press(1'b1, 1'b0);

    t = cyc;
    ex(t + 6, G_MODE,  2, "both_early_mode");
    ex(t + 6, G_HL,    0, "both_early_hl");
    ex(t + 7, G_MODE,  3, "both_mode_reg");
    ex(t + 7, G_HL,    1, "both_hl");
    ex(t + 7, G_RADDR, 0, "reg_raddr0");
    ex(t + 8, G_DATA,  32'hA500_0000, "data_reg0");
    press(1'b1, 1'b1);

    for (int i = 1; i <= 31; i++) begin
      t = cyc;
      ex(t + 7, G_RADDR, i, "reg_step");
      if (i == 31) begin
        ex(t + 7, G_MODE, 3, "reg_mode31");
        ex(t + 8, G_DATA, 32'hA500_001F, "data_reg31");
      end
      press(1'b1, 1'b0);
    end

    t = cyc;
    ex(t + 6, G_RADDR, 31, "wrap_early");
    ex(t + 7, G_RADDR, 0, "wrap_raddr");
    ex(t + 7, G_MODE,  0, "wrap_mode");
    ex(t + 8, G_DATA,  32'h0040_0004, "wrap_data");
    press(1'b1, 1'b0);

    t = cyc;
    ex(t + 6, G_HL, 1, "half_early");
    ex(t + 7, G_HL, 0, "half_toggle0");
    ex(t + 7, G_MODE, 0, "half_mode_keep");
    press(1'b0, 1'b1);
    t = cyc;
    ex(t + 7, G_HL, 1, "half_toggle1");
    press(1'b0, 1'b1);

    for (int i = 1; i <= 10; i++) begin
      t = cyc;
      if (i == 10) begin
        ex(t + 7, G_RADDR, 7, "pre_rst_raddr");
        ex(t + 7, G_MODE,  3, "pre_rst_mode");
      end
      press(1'b1, 1'b0);
    end

    bn = 1'b1;
    tick(3);
    t = cyc;
    rst = 1'b1;
    ex(t + 1, G_MODE,  0, "rst2_mode");
    ex(t + 1, G_RADDR, 0, "rst2_raddr");
    ex(t + 1, G_HL,    0, "rst2_hilo");
    ex(t + 1, G_DATA,  0, "rst2_data");
    ex(t + 1, G_SCAN,  0, "rst2_scan");
    ex(t + 1, G_HLA,   0, "rst2_hla");
    tick(1);
    rst = 1'b0;
    r = cyc;
    ex(r + 1, G_DATA,  32'h0040_0004, "rst2_data_pc");
    ex(r + 3, G_MODE,  0, "rst2_no_old_press");
    ex(r + 6, G_MODE,  0, "rst2_redebounce");
    ex(r + 7, G_MODE,  1, "rst2_mode1");
    ex(r + 8, G_DATA,  32'h8C08_0004, "rst2_data_instr");
    ex(r + 2, G_DATAA, 32'h0040_0004, "auto_data");
    ex(r + 5, G_SCANA, 1, "auto_scan");
    ex(r + 9,  G_HLA, 0, "auto_before");
    ex(r + 10, G_HLA, 1, "auto_t10");
    ex(r + 19, G_HLA, 1, "auto_hold");
    ex(r + 20, G_HLA, 0, "auto_t20");
    ex(r + 29, G_HLA, 0, "coinc_before");
    ex(r + 30, G_HLA, 1, "coinc_single");
    ex(r + 39, G_HLA, 1, "coinc_hold");
    ex(r + 40, G_HLA, 0, "coinc_next_auto");
    ex(r + 44, G_HLA, 0, "clr_before");
    ex(r + 45, G_HLA, 1, "clr_press");
    ex(r + 50, G_HLA, 1, "clr_no_old_wrap");
    ex(r + 54, G_HLA, 1, "clr_hold");
    ex(r + 55, G_HLA, 0, "clr_new_wrap");
    ex(r + 50, G_MODEA, 0, "auto_mode");
    ex(r + 50, G_RADA,  0, "auto_raddr");

    fork
      begin
        tick(10);
        bn = 1'b0;
      end
      begin
        wait_cyc(r + 23);
        bh_a = 1'b1;
        tick(6);
        bh_a = 1'b0;
        wait_cyc(r + 38);
        bh_a = 1'b1;
        tick(6);
        bh_a = 1'b0;
      end
    join

    wait_cyc(max_at + 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
